bscan_input_cell_chain: RTL and testbench

- Input-direction boundary-scan block: receives N pad inputs, synchronises them and forwards them to the core.
- Provides capture/shift/update scan cells for board-level test.
- Complements the output-buffer boundary-scan cells: those drive pads, this block samples them.
- Sits between input pads and core logic, daisy-chained into the DR scan path under TAP strobes.

---
 rtl/bscan_input_cell_chain.sv | 89 ++++++++
 tb/tb_bscan_input_cell_chain.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bscan_input_cell_chain.sv
// Input-direction boundary-scan chain: synchronises N pad inputs for the core
// and provides capture/shift/update scan cells daisy-chained into the DR path.
// TDO is cell 0; the first bit shifted out is the one captured from pad 0.
module bscan_input_cell_chain #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] PAD_IN,
    output logic [N-1:0] CORE_IN,
    input  logic         TDI,
    output logic         TDO,
    input  logic         CAPTURE,
    input  logic         SHIFT,
    input  logic         UPDATE,
    input  logic         EXTEST,
    output logic         DONE
);

    // Counter is wide enough to hold N itself.
    localparam int CW = $clog2(N) + 1;

    logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
    logic [N-1:0]                  shift_reg_q, shift_reg_d;
    logic [N-1:0]                  update_latch_q, update_latch_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          done_q, done_d;
    logic [N-1:0]                  pad_s;

    assign pad_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 samples the raw pads, each later stage copies the previous one.
    always_comb begin
        sync_d[0] = PAD_IN;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Scan cell next state: capture beats shift, shift beats hold; update is independent.
    always_comb begin
        // NOTE: every signal gets a default before the branches so no path leaves one unassigned, which would infer a latch.
        shift_reg_d    = shift_reg_q;
        cnt_d          = cnt_q;
        done_d         = 1'b0;
        update_latch_d = UPDATE ? shift_reg_q : update_latch_q;

        if (CAPTURE) begin
            shift_reg_d = pad_s;
            cnt_d       = '0;
        end else if (SHIFT) begin
            shift_reg_d = {TDI, shift_reg_q[N-1:1]};
            if (cnt_q == CW'(N - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the synchroniser array is reset too, so CORE_IN is a known 0 from the first cycle.
            sync_q         <= '0;
            shift_reg_q    <= '0;
            update_latch_q <= '0;
            cnt_q          <= '0;
            done_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, e.g. update takes the pre-shift register.
            sync_q         <= sync_d;
            shift_reg_q    <= shift_reg_d;
            update_latch_q <= update_latch_d;
            cnt_q          <= cnt_d;
            done_q         <= done_d;
        end
    end

    // Output mux: in EXTEST the core sees the update latch instead of the pads.
    always_comb begin
        CORE_IN = EXTEST ? update_latch_q : pad_s;
        TDO     = shift_reg_q[0];
        DONE    = done_q;
    end

endmodule

// File: tb/tb_bscan_input_cell_chain.sv
// Directed bench for bscan_input_cell_chain with N=4, SYNC_STAGES=2.
module tb_bscan_input_cell_chain;

    logic       CLK;
    logic       RST;
    logic [3:0] PAD_IN;
    logic [3:0] CORE_IN;
    logic       TDI;
    logic       TDO;
    logic       CAPTURE;
    logic       SHIFT;
    logic       UPDATE;
    logic       EXTEST;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    bscan_input_cell_chain #(.N(4), .SYNC_STAGES(2)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .PAD_IN  (PAD_IN),
        .CORE_IN (CORE_IN),
        .TDI     (TDI),
        .TDO     (TDO),
        .CAPTURE (CAPTURE),
        .SHIFT   (SHIFT),
        .UPDATE  (UPDATE),
        .EXTEST  (EXTEST),
        .DONE    (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge, then step off it for driving and sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; PAD_IN = 4'b1010; TDI = 1'b0; CAPTURE = 1'b0;
        SHIFT = 1'b0; UPDATE = 1'b0; EXTEST = 1'b0;
        tick(); tick();
        checks++; if (CORE_IN !== 4'b0000) begin errors++; $display("FAIL reset_core_in: got %b exp 0000", CORE_IN); end
        checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b exp 0", TDO); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", DONE); end
        checks++; if (dut.shift_reg_q !== 4'b0000) begin errors++; $display("FAIL reset_shift_reg: got %b exp 0000", dut.shift_reg_q); end
        RST = 1'b0;
        tick();
        checks++; if (CORE_IN !== 4'b0000) begin errors++; $display("FAIL sync_latency_1: got %b exp 0000", CORE_IN); end
        tick();
        checks++; if (CORE_IN !== 4'b1010) begin errors++; $display("FAIL sync_latency_2: got %b exp 1010", CORE_IN); end
    endtask

    task automatic test_capture_shift();
        logic [3:0] exp_tdo;
        exp_tdo = 4'b1011; // bit i = expected TDO before shift i
        PAD_IN = 4'b1011;
        tick(); tick(); tick();
        CAPTURE = 1'b1;
        tick();
        CAPTURE = 1'b0;
        checks++; if (dut.shift_reg_q !== 4'b1011) begin errors++; $display("FAIL capture_value: got %b exp 1011", dut.shift_reg_q); end
        SHIFT = 1'b1; TDI = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (TDO !== exp_tdo[i]) begin errors++; $display("FAIL tdo_bit%0d: got %b exp %b", i, TDO, exp_tdo[i]); end
            tick();
            checks++; if (DONE !== (i == 3)) begin errors++; $display("FAIL done_shift%0d: got %b exp %b", i, DONE, (i == 3)); end
        end
        SHIFT = 1'b0;
        checks++; if (dut.shift_reg_q !== 4'b0000) begin errors++; $display("FAIL shift_out_empty: got %b exp 0000", dut.shift_reg_q); end
        tick();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b exp 0", DONE); end
    endtask

    task automatic test_update_extest();
        logic [3:0] tdi_seq;
        logic [3:0] pads [3];
        tdi_seq = 4'b1001; // bit i driven on shift i: 1,0,0,1
        pads[0] = 4'b0000; pads[1] = 4'b1111; pads[2] = 4'b0101;
        SHIFT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            TDI = tdi_seq[i];
            tick();
        end
        SHIFT = 1'b0;
        checks++; if (dut.shift_reg_q !== 4'b1001) begin errors++; $display("FAIL load_1001: got %b exp 1001", dut.shift_reg_q); end
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        EXTEST = 1'b1;
        #1;
        checks++; if (CORE_IN !== 4'b1001) begin errors++; $display("FAIL extest_core_in: got %b exp 1001", CORE_IN); end
        for (int i = 0; i < 3; i++) begin
            PAD_IN = pads[i];
            tick(); tick(); tick();
            checks++; if (CORE_IN !== 4'b1001) begin errors++; $display("FAIL extest_pad_toggle%0d: got %b exp 1001", i, CORE_IN); end
        end
        PAD_IN = 4'b0011;
        tick(); tick(); tick();
        checks++; if (CORE_IN !== 4'b1001) begin errors++; $display("FAIL extest_hold: got %b exp 1001", CORE_IN); end
        EXTEST = 1'b0;
        #1;
        checks++; if (CORE_IN !== 4'b0011) begin errors++; $display("FAIL extest_release: got %b exp 0011", CORE_IN); end
    endtask

    task automatic test_capture_priority();
        PAD_IN = 4'b0110;
        tick(); tick(); tick();
        SHIFT = 1'b1; TDI = 1'b1;
        tick(); tick();
        checks++; if (dut.cnt_q !== 3'd2) begin errors++; $display("FAIL pre_capture_count: got %0d exp 2", dut.cnt_q); end
        CAPTURE = 1'b1;
        tick();
        CAPTURE = 1'b0;
        checks++; if (dut.shift_reg_q !== 4'b0110) begin errors++; $display("FAIL capture_over_shift: got %b exp 0110", dut.shift_reg_q); end
        checks++; if (dut.cnt_q !== 3'd0) begin errors++; $display("FAIL capture_clears_count: got %0d exp 0", dut.cnt_q); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (DONE !== (i == 3)) begin errors++; $display("FAIL post_capture_done%0d: got %b exp %b", i, DONE, (i == 3)); end
        end
        SHIFT = 1'b0;
    endtask

    task automatic test_hold_count();
        SHIFT = 1'b1; TDI = 1'b0;
        tick();
        SHIFT = 1'b0;
        tick(); tick(); tick();
        checks++; if (dut.cnt_q !== 3'd1) begin errors++; $display("FAIL hold_count: got %0d exp 1", dut.cnt_q); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL hold_done: got %b exp 0", DONE); end
    endtask

    task automatic test_reset_mid_shift();
        SHIFT = 1'b1; TDI = 1'b1;
        tick(); tick();
        #2;
        RST = 1'b1;
        #1;
        checks++; if (dut.shift_reg_q !== 4'b0000) begin errors++; $display("FAIL mid_reset_shift_reg: got %b exp 0000", dut.shift_reg_q); end
        checks++; if (dut.cnt_q !== 3'd0) begin errors++; $display("FAIL mid_reset_count: got %0d exp 0", dut.cnt_q); end
        checks++; if (CORE_IN !== 4'b0000) begin errors++; $display("FAIL mid_reset_core_in: got %b exp 0000", CORE_IN); end
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (DONE !== (i == 3)) begin errors++; $display("FAIL post_reset_done%0d: got %b exp %b", i, DONE, (i == 3)); end
        end
        checks++; if (dut.shift_reg_q !== 4'b1111) begin errors++; $display("FAIL post_reset_fill: got %b exp 1111", dut.shift_reg_q); end
    endtask

    task automatic test_back_to_back();
        // SHIFT is still high from the previous scenario: the next count starts with no gap.
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (DONE !== (i == 3)) begin errors++; $display("FAIL b2b_done%0d: got %b exp %b", i, DONE, (i == 3)); end
        end
        SHIFT = 1'b0;
    endtask

    task automatic test_update_during_shift();
        logic [3:0] tdi_seq;
        tdi_seq = 4'b1100; // shifts in 0,0,1,1 -> register 1100
        SHIFT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            TDI = tdi_seq[i];
            tick();
        end
        checks++; if (dut.shift_reg_q !== 4'b1100) begin errors++; $display("FAIL load_1100: got %b exp 1100", dut.shift_reg_q); end
        TDI = 1'b1; UPDATE = 1'b1;
        tick();
        SHIFT = 1'b0; UPDATE = 1'b0;
        checks++; if (dut.shift_reg_q !== 4'b1110) begin errors++; $display("FAIL shift_with_update: got %b exp 1110", dut.shift_reg_q); end
        EXTEST = 1'b1;
        #1;
        checks++; if (CORE_IN !== 4'b1100) begin errors++; $display("FAIL update_pre_shift: got %b exp 1100", CORE_IN); end
        EXTEST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture_shift();
        test_update_extest();
        test_capture_priority();
        test_hold_count();
        test_reset_mid_shift();
        test_back_to_back();
        test_update_during_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
